// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// It grants one requester and latches its byte, then pulses tx_start once.
// It waits for tx_done_tick (or a timeout), acknowledges the requester and
// holds off for GAP_CYCLES idle cycles before the next grant.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int DBIT       = 8,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 200_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DBIT-1:0]    req_data,
  output logic [NREQ-1:0]         ack,
  output logic                    tx_start,
  output logic [DBIT-1:0]         tx_data,
  input  logic                    tx_done_tick,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    timeout_err
);

  localparam int PW   = $clog2(NREQ);
  localparam int CMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_GAP} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, r_grant;
  logic [DBIT-1:0] r_tx_data;
  logic [NREQ-1:0] r_ack;
  logic            r_err;
  logic [CW-1:0]   r_cnt;

  logic [PW-1:0]   w_sel, w_cand;
  logic            w_found, w_tmo, w_end, w_gap_end;

  // Round-robin search: first pending request after the last granted index
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // A done tick on the terminal count still wins over the timeout
  assign w_tmo     = (r_state == S_BUSY) && (r_cnt == TMO_LAST);
  assign w_end     = (r_state == S_BUSY) && (tx_done_tick || w_tmo);
  assign w_gap_end = (r_state == S_GAP) && (r_cnt == GAP_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a zero-length gap returns straight to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_START;
      S_START: w_state_nxt = S_BUSY;
      S_BUSY:  if (w_end) w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (w_gap_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant/data latch, shared timeout/gap counter, ack and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= PW'(NREQ - 1);
      r_grant   <= '0;
      r_tx_data <= '0;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_grant   <= w_sel;
            r_tx_data <= req_data[int'(w_sel)*DBIT +: DBIT];
          end
        end
        S_START: r_cnt <= '0;
        S_BUSY: begin
          if (w_end) begin
            r_ptr <= r_grant;
            r_cnt <= '0;
            if (tx_done_tick) r_ack[r_grant] <= 1'b1;
            else              r_err          <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: r_cnt <= w_gap_end ? '0 : r_cnt + 1'b1;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign tx_start    = (r_state == S_START);
  assign busy        = (r_state != S_IDLE);
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant;
  assign ack         = r_ack;
  assign timeout_err = r_err;

endmodule
